sram_dp_arbiter: RTL and testbench
==================================

SRAM_DP_ARBITER -- requirements
Module: sram_dp_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 4, number of requesters (2..8); ADDR_W, default 7, SRAM address width; DATA_W, default 16, SRAM data width.
REQ-002 SHALL have ports (name, direction, width, meaning), in this order:
  CLK  in  1  single clock, rising edge
  RST  in  1  asynchronous, active-high reset
  req_valid  in  NUM_REQ  per-requester request valid
  req_ready  out  NUM_REQ  per-requester grant; the request is accepted when valid and ready are both high
  req_we  in  NUM_REQ  1 = write, 0 = read
  req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W]
  req_wdata  in  NUM_REQ*DATA_W  packed write data
  req_wmask  in  NUM_REQ*DATA_W  packed bit write-enable mask
  rsp_valid  out  NUM_REQ  one-hot read-data-valid per requester
  rsp_rdata  out  NUM_REQ*DATA_W  packed read data
  A0/A1  out  ADDR_W  SRAM port 0/1 address
  D0/D1  out  DATA_W  SRAM port 0/1 write data
  WEM0/WEM1  out  DATA_W  SRAM port 0/1 write mask
  WE0/WE1  out  1  SRAM port 0/1 write enable, active high
  CE0/CE1  out  1  SRAM port 0/1 chip enable, active high
  Q0/Q1  in  DATA_W  SRAM port 0/1 read data, valid one cycle after CE

Function
REQ-003 SHALL grant at most two requests per cycle using rotating priority that starts at pointer rr_ptr (NUM_REQ-bit one-hot).
REQ-004 SHALL map the first winner in priority order to port 0 and the second winner to port 1.
REQ-005 SHALL make req_ready combinational from req_valid, req_we, req_addr and rr_ptr; req_ready[i] SHALL be high only if req_valid[i] is high.
REQ-006 SHALL detect an address conflict when the second candidate's address equals the first winner's address and at least one of the two is a write; on a conflict, the second candidate SHALL NOT be granted in that cycle, and candidate search SHALL continue to the next requester in priority order.
REQ-007 SHALL register the SRAM outputs: on each granted cycle, CE0/CE1, WE0/WE1, A, D and WEM SHALL be driven on the following cycle.
REQ-008 SHALL drive CE low and WE, A, D, WEM to 0 on any port that has no grant.
REQ-009 SHALL track each issued read in a per-port tag pipeline (requester ID plus valid bit).
REQ-010 SHALL assert rsp_valid[id] for exactly one cycle with rsp_rdata[id] = Q of that port; base latency is 2 cycles from the handshake (grant register stage plus SRAM access).
REQ-011 SHALL hold rsp_rdata slices not asserted in rsp_valid at their previous value.
REQ-012 SHALL advance rr_ptr, after any cycle with at least one grant, to the requester one past the last granted requester, wrapping from NUM_REQ-1 to 0; rr_ptr SHALL be unchanged when there is no grant.
REQ-013 SHALL apply writes with no read-modify-write; a read to the same address as a write in a later cycle SHALL return the new data.
REQ-014 SHALL grant only one request when only one valid request exists, on port 0.

Reset
REQ-015 SHALL, while RST is high, force: rr_ptr = requester 0; CE0 = CE1 = WE0 = WE1 = 0; A, D, WEM = 0; tag pipelines invalid; rsp_valid = 0; rsp_rdata = 0; req_ready = 0.
REQ-016 SHALL discard reads in flight when RST is asserted mid-operation; no rsp_valid SHALL appear for them after RST deasserts.

Configuration
REQ-017 SHALL support macro SRAM_ARB_RDATA_REG_EN.
  Defined: adds a register stage on Q0/Q1 and on the tags; read latency becomes 3 cycles; rsp_rdata changes only on the rsp_valid cycle.
  Undefined: latency is 2 cycles and rsp_rdata is driven from the SRAM Q path.

Verification
REQ-018 Scenario, reset: hold RST during traffic -> all outputs 0, and after release rr_ptr = 0 and no rsp_valid.
REQ-019 Scenario, full load: all 4 requesters valid reading addrs 0x10..0x13 -> grants {0,1}, then {2,3}, then {0,1} ...; each rsp_valid occurs exactly 2 cycles after its handshake.
REQ-020 Scenario, write conflict: req0 writes 0x55 = 16'hA5A5, req1 reads 0x55, same cycle -> only req0 granted; req1 granted the next cycle and returns 16'hA5A5.
REQ-021 Scenario, write mask: write 0x7F = 16'hFFFF, then write 16'h0000 with WEM = 16'h00FF, then read -> 16'hFF00.
REQ-022 Scenario, wrap-around: only req3 and req0 valid with rr_ptr = 3 -> req3 on port 0, req0 on port 1, then rr_ptr = 1.
REQ-023 Scenario, macro: with SRAM_ARB_RDATA_REG_EN defined, rerun REQ-019 -> latency 3 cycles, identical data.

Source files
------------

// File: rtl/sram_dp_arbiter.sv
// sram_dp_arbiter: shares one dual-port SRAM among NUM_REQ requesters.
// Up to two requests are granted per cycle with rotating priority. The first winner goes to
// port 0 and the second to port 1. A second candidate that hits the first winner's address,
// where either side is a write, is skipped in favour of the next requester in order.
// SRAM controls are registered, and read responses come back through per-port tag pipelines.
// Optional macro SRAM_ARB_RDATA_REG_EN registers Q0/Q1 and the tags. This makes read latency
// 3 cycles instead of 2.
module sram_dp_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wmask,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]           A0,
  output logic [ADDR_W-1:0]           A1,
  output logic [DATA_W-1:0]           D0,
  output logic [DATA_W-1:0]           D1,
  output logic [DATA_W-1:0]           WEM0,
  output logic [DATA_W-1:0]           WEM1,
  output logic                        WE0,
  output logic                        WE1,
  output logic                        CE0,
  output logic                        CE1,
  input  logic [DATA_W-1:0]           Q0,
  input  logic [DATA_W-1:0]           Q1
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Unpacked views of the request buses
  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];
  logic [DATA_W-1:0] wmask_a [NUM_REQ];

  // Rotating priority pointer, one-hot
  logic [NUM_REQ-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    ptr_idx;

  // Arbitration results
  logic               first_found, second_found;
  logic [ID_W-1:0]    first_id, second_id;
  logic [ID_W-1:0]    last_id, next_id;

  // Read tag pipelines, one entry per SRAM port
  logic [1:0]         t1_v, t2_v;
  logic [ID_W-1:0]    t1_id [2];
  logic [ID_W-1:0]    t2_id [2];
  logic [1:0]         out_v;
  logic [ID_W-1:0]    out_id [2];
  logic [DATA_W-1:0]  q_a [2];

  // Last delivered read data per requester
  logic [DATA_W-1:0]  hold_q [NUM_REQ];

  assign q_a[0] = Q0;
  assign q_a[1] = Q1;

  // Split packed request buses into per-requester fields
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
      wmask_a[i] = req_wmask[i*DATA_W +: DATA_W];
    end
  end

  // Convert the one-hot pointer to an index
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_ptr_q[i]) ptr_idx = ID_W'(i);
    end
  end

  // Walk requesters from the pointer; pick the first valid and the next non-conflicting one
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] cand;
    idx          = 0;
    cand         = '0;
    first_found  = 1'b0;
    second_found = 1'b0;
    first_id     = '0;
    second_id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_idx) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (req_valid[cand] && !RST) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_id    = cand;
        end else if (!second_found &&
                     !((addr_a[cand] == addr_a[first_id]) &&
                       (req_we[cand] || req_we[first_id]))) begin
          second_found = 1'b1;
          second_id    = cand;
        end
      end
    end
  end

  // Grant vector and next pointer (one past the last winner)
  always_comb begin
    req_ready = '0;
    if (first_found)  req_ready[first_id]  = 1'b1;
    if (second_found) req_ready[second_id] = 1'b1;
    last_id  = second_found ? second_id : first_id;
    next_id  = (last_id == ID_W'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (first_found) begin
      rr_ptr_d          = '0;
      rr_ptr_d[next_id] = 1'b1;
    end
  end

  // Priority pointer state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr_q <= NUM_REQ'(1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Registered SRAM port controls; idle ports drive all zeros
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CE0  <= 1'b0;
      WE0  <= 1'b0;
      A0   <= '0;
      D0   <= '0;
      WEM0 <= '0;
      CE1  <= 1'b0;
      WE1  <= 1'b0;
      A1   <= '0;
      D1   <= '0;
      WEM1 <= '0;
    end else begin
      CE0  <= first_found;
      WE0  <= first_found & req_we[first_id];
      A0   <= first_found ? addr_a[first_id]  : '0;
      D0   <= first_found ? wdata_a[first_id] : '0;
      WEM0 <= first_found ? wmask_a[first_id] : '0;
      CE1  <= second_found;
      WE1  <= second_found & req_we[second_id];
      A1   <= second_found ? addr_a[second_id]  : '0;
      D1   <= second_found ? wdata_a[second_id] : '0;
      WEM1 <= second_found ? wmask_a[second_id] : '0;
    end
  end

  // Tag pipeline: stage 1 aligns with the SRAM command, stage 2 with Q
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      t1_v     <= '0;
      t2_v     <= '0;
      t1_id[0] <= '0;
      t1_id[1] <= '0;
      t2_id[0] <= '0;
      t2_id[1] <= '0;
    end else begin
      t1_v[0]  <= first_found & ~req_we[first_id];
      t1_v[1]  <= second_found & ~req_we[second_id];
      t1_id[0] <= first_id;
      t1_id[1] <= second_id;
      t2_v     <= t1_v;
      t2_id[0] <= t1_id[0];
      t2_id[1] <= t1_id[1];
    end
  end

  // Capture returning read data per requester
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REQ; i++) hold_q[i] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (t2_v[p]) hold_q[t2_id[p]] <= q_a[p];
      end
    end
  end

`ifdef SRAM_ARB_RDATA_REG_EN
  logic [1:0]      t3_v;
  logic [ID_W-1:0] t3_id [2];

  // Extra tag stage that lines up with the registered read data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      t3_v     <= '0;
      t3_id[0] <= '0;
      t3_id[1] <= '0;
    end else begin
      t3_v     <= t2_v;
      t3_id[0] <= t2_id[0];
      t3_id[1] <= t2_id[1];
    end
  end

  assign out_v     = t3_v;
  assign out_id[0] = t3_id[0];
  assign out_id[1] = t3_id[1];

  // Read data comes only from the capture registers
  always_comb begin
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_rdata[i*DATA_W +: DATA_W] = hold_q[i];
    end
  end
`else
  assign out_v     = t2_v;
  assign out_id[0] = t2_id[0];
  assign out_id[1] = t2_id[1];

  // Responding slices take Q directly; others hold their last value
  always_comb begin
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_rdata[i*DATA_W +: DATA_W] = hold_q[i];
      for (int p = 0; p < 2; p++) begin
        if (t2_v[p] && (t2_id[p] == ID_W'(i))) rsp_rdata[i*DATA_W +: DATA_W] = q_a[p];
      end
    end
  end
`endif

  // Decode response valids from the final tag stage
  always_comb begin
    rsp_valid = '0;
    for (int p = 0; p < 2; p++) begin
      if (out_v[p]) rsp_valid[out_id[p]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Bench for sram_dp_arbiter: directed scenarios with literal expectations, plus a
// transaction-level model checked on every falling edge.
module tb_sram_dp_arbiter;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 16;
`ifdef SRAM_ARB_RDATA_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, req_wmask, rsp_rdata;
  logic [AW-1:0] A0, A1;
  logic [DW-1:0] D0, D1, WEM0, WEM1, Q0, Q1;
  logic          WE0, WE1, CE0, CE1;

  // Stimulus state
  logic [N-1:0]  s_valid, s_we;
  logic [AW-1:0] s_addr  [N];
  logic [DW-1:0] s_wdata [N];
  logic [DW-1:0] s_wmask [N];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    req_valid = s_valid;
    req_we    = s_we;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = s_addr[i];
      req_wdata[i*DW +: DW] = s_wdata[i];
      req_wmask[i*DW +: DW] = s_wmask[i];
    end
  end

  sram_dp_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .A0(A0), .A1(A1), .D0(D0), .D1(D1), .WEM0(WEM0), .WEM1(WEM1),
    .WE0(WE0), .WE1(WE1), .CE0(CE0), .CE1(CE1), .Q0(Q0), .Q1(Q1)
  );

  // Dual-port SRAM: masked write, read returns the old contents one cycle later
  logic [DW-1:0] mem [2**AW];
  always @(posedge CLK) begin
    if (CE0) begin
      if (WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
      Q0 <= mem[A0];
    end
    if (CE1) begin
      if (WE1) mem[A1] <= (mem[A1] & ~WEM1) | (D1 & WEM1);
      Q1 <= mem[A1];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: memory contents as seen by accepted transactions, expected port commands,
  // scheduled responses indexed by cycle, and per-requester last read data.
  logic [DW-1:0] ref_mem [2**AW];
  int            m_rr;
  logic          m_ce [2];
  logic          m_we [2];
  logic [AW-1:0] m_a  [2];
  logic [DW-1:0] m_d  [2];
  logic [DW-1:0] m_wem [2];
  logic [N-1:0]  sched_v [8];
  logic [DW-1:0] sched_d [8][N];
  logic [DW-1:0] m_hold [N];
  int            cyc = 0;
  int            win [2];
  int            cid, slot, nslot, last_w, wp;
  logic [N-1:0]  g;
  logic [N*DW-1:0] exp_rd;

  initial begin
    for (int a = 0; a < 2**AW; a++) begin
      mem[a]     <= DW'(16'hB000 | a);
      ref_mem[a] = DW'(16'hB000 | a);
    end
  end

  // Compare process: checks all outputs each cycle, then advances the model
  always @(negedge CLK) begin
    slot = cyc % 8;
    if (RST) begin
      chk("rst_ready", 128'(req_ready), 128'(0));
      chk("rst_sram", 128'({CE0, CE1, WE0, WE1, A0, A1, D0, D1, WEM0, WEM1}), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_rdata", 128'(rsp_rdata), 128'(0));
      m_rr = 0;
      for (int p = 0; p < 2; p++) begin
        m_ce[p] = 0; m_we[p] = 0; m_a[p] = '0; m_d[p] = '0; m_wem[p] = '0;
      end
      for (int s = 0; s < 8; s++) sched_v[s] = '0;
      for (int i = 0; i < N; i++) m_hold[i] = '0;
    end else begin
      // Winners in rotating order: first valid, then next valid without address hazard
      win[0] = -1;
      win[1] = -1;
      for (int k = 0; k < N; k++) begin
        cid = (m_rr + k) % N;
        if (s_valid[cid]) begin
          if (win[0] < 0) win[0] = cid;
          else if (win[1] < 0 && !(s_addr[cid] == s_addr[win[0]] &&
                                   (s_we[cid] || s_we[win[0]]))) win[1] = cid;
        end
      end
      g = '0;
      for (int p = 0; p < 2; p++) if (win[p] >= 0) g[win[p]] = 1'b1;
      chk("ready", 128'(req_ready), 128'(g));
      chk("port0", 128'({CE0, WE0, A0, D0, WEM0}),
          128'({m_ce[0], m_we[0], m_a[0], m_d[0], m_wem[0]}));
      chk("port1", 128'({CE1, WE1, A1, D1, WEM1}),
          128'({m_ce[1], m_we[1], m_a[1], m_d[1], m_wem[1]}));
      chk("rsp_valid", 128'(rsp_valid), 128'(sched_v[slot]));
      for (int i = 0; i < N; i++) begin
        if (sched_v[slot][i]) m_hold[i] = sched_d[slot][i];
        exp_rd[i*DW +: DW] = m_hold[i];
      end
      chk("rsp_rdata", 128'(rsp_rdata), 128'(exp_rd));
      sched_v[slot] = '0;
      // Next-cycle port commands and response schedule
      nslot = (cyc + LAT) % 8;
      for (int p = 0; p < 2; p++) begin
        wp = win[p];
        if (wp >= 0) begin
          m_ce[p] = 1'b1; m_we[p] = s_we[wp]; m_a[p] = s_addr[wp];
          m_d[p] = s_wdata[wp]; m_wem[p] = s_wmask[wp];
          if (!s_we[wp]) begin
            sched_v[nslot][wp] = 1'b1;
            sched_d[nslot][wp] = ref_mem[s_addr[wp]];
          end
        end else begin
          m_ce[p] = 0; m_we[p] = 0; m_a[p] = '0; m_d[p] = '0; m_wem[p] = '0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        wp = win[p];
        if (wp >= 0 && s_we[wp])
          ref_mem[s_addr[wp]] = (ref_mem[s_addr[wp]] & ~s_wmask[wp]) | (s_wdata[wp] & s_wmask[wp]);
      end
      last_w = (win[1] >= 0) ? win[1] : win[0];
      if (win[0] >= 0) m_rr = (last_w + 1) % N;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    s_valid = '0;
    s_we    = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
    s_valid[i] = 1'b1;
    s_we[i]    = we;
    s_addr[i]  = a;
    s_wdata[i] = d;
    s_wmask[i] = m;
  endtask

  // Idle until the response to the last handshake is due
  task automatic wait_rsp();
    repeat (LAT) begin
      tick();
      idle_all();
      @(negedge CLK);
    end
  endtask

  initial begin
    idle_all();
    for (int i = 0; i < N; i++) begin
      s_addr[i] = '0; s_wdata[i] = '0; s_wmask[i] = '0;
    end
    // Traffic held under reset: nothing may be granted
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(8'h10 + i), '0, '0);
    repeat (3) begin
      @(negedge CLK);
      chk("lit_rst_ready", 128'(req_ready), 128'(0));
      tick();
    end
    // Full load after release: pairs {0,1},{2,3} alternate
    RST = 1'b0;
    @(negedge CLK);
    chk("lit_full_ready0", 128'(req_ready), 128'(4'b0011));
    for (int c = 1; c <= 5; c++) begin
      tick();
      @(negedge CLK);
      chk("lit_full_ready", 128'(req_ready), 128'((c % 2 == 1) ? 4'b1100 : 4'b0011));
      if (c == LAT - 1) chk("lit_full_early", 128'(rsp_valid), 128'(0));
      if (c == LAT) begin
        chk("lit_full_rv0", 128'(rsp_valid), 128'(4'b0011));
        chk("lit_full_rd0", 128'(rsp_rdata[15:0]), 128'(16'hB010));
        chk("lit_full_rd1", 128'(rsp_rdata[31:16]), 128'(16'hB011));
      end
      if (c == LAT + 1) begin
        chk("lit_full_rv1", 128'(rsp_valid), 128'(4'b1100));
        chk("lit_full_rd3", 128'(rsp_rdata[63:48]), 128'(16'hB013));
      end
    end
    // Reset with reads in flight: they must never respond
    tick();
    RST = 1'b1;
    idle_all();
    @(negedge CLK);
    chk("lit_midrst_rv", 128'(rsp_valid), 128'(0));
    tick();
    tick();
    RST = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      chk("lit_postrst_rv", 128'(rsp_valid), 128'(0));
      tick();
    end
    // Write/read conflict on 0x55
    set_req(0, 1'b1, 7'h55, 16'hA5A5, 16'hFFFF);
    set_req(1, 1'b0, 7'h55, 16'h0000, 16'h0000);
    @(negedge CLK);
    chk("lit_conf_ready0", 128'(req_ready), 128'(4'b0001));
    tick();
    s_valid[0] = 1'b0;
    @(negedge CLK);
    chk("lit_conf_ready1", 128'(req_ready), 128'(4'b0010));
    wait_rsp();
    chk("lit_conf_rv", 128'(rsp_valid), 128'(4'b0010));
    chk("lit_conf_rd", 128'(rsp_rdata[31:16]), 128'(16'hA5A5));
    // Write mask on 0x7F
    tick();
    set_req(2, 1'b1, 7'h7F, 16'hFFFF, 16'hFFFF);
    @(negedge CLK);
    chk("lit_mask_ready0", 128'(req_ready), 128'(4'b0100));
    tick();
    set_req(2, 1'b1, 7'h7F, 16'h0000, 16'h00FF);
    @(negedge CLK);
    chk("lit_mask_ready1", 128'(req_ready), 128'(4'b0100));
    tick();
    set_req(2, 1'b0, 7'h7F, 16'h0000, 16'h0000);
    @(negedge CLK);
    chk("lit_mask_ready2", 128'(req_ready), 128'(4'b0100));
    wait_rsp();
    chk("lit_mask_rv", 128'(rsp_valid), 128'(4'b0100));
    chk("lit_mask_rd", 128'(rsp_rdata[47:32]), 128'(16'hFF00));
    // Wrap-around from pointer 3
    tick();
    idle_all();
    set_req(3, 1'b0, 7'h20, 16'h0, 16'h0);
    set_req(0, 1'b0, 7'h21, 16'h0, 16'h0);
    @(negedge CLK);
    chk("lit_wrap_ready", 128'(req_ready), 128'(4'b1001));
    tick();
    idle_all();
    set_req(0, 1'b0, 7'h30, 16'h0, 16'h0);
    set_req(1, 1'b0, 7'h31, 16'h0, 16'h0);
    @(negedge CLK);
    chk("lit_wrap_ports", 128'({CE0, CE1, A0, A1}), 128'({2'b11, 7'h20, 7'h21}));
    chk("lit_wrap_ready2", 128'(req_ready), 128'(4'b0011));
    tick();
    idle_all();
    @(negedge CLK);
    chk("lit_wrap_ptr1", 128'({A0, A1}), 128'({7'h31, 7'h30}));
    // Conflict skip: req2 blocked by req1's write, req3 takes port 1
    tick();
    set_req(1, 1'b1, 7'h40, 16'h1234, 16'hFFFF);
    set_req(2, 1'b0, 7'h40, 16'h0, 16'h0);
    set_req(3, 1'b0, 7'h41, 16'h0, 16'h0);
    @(negedge CLK);
    chk("lit_skip_ready", 128'(req_ready), 128'(4'b1010));
    // Mixed traffic on a small address window, checked by the model
    for (int n = 0; n < 40; n++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        s_valid[i] = 1'($urandom_range(0, 1));
        s_we[i]    = 1'($urandom_range(0, 1));
        s_addr[i]  = AW'(32'h40 + $urandom_range(0, 3));
        s_wdata[i] = DW'($urandom);
        s_wmask[i] = DW'($urandom);
      end
    end
    tick();
    idle_all();
    repeat (6) tick();
    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
